// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 brute-force key scheduler.
// Imported by the scheduler top; the picker is type-agnostic.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        ABORT = 3'd2,
        FAIL  = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    localparam int KEY_WIDTH_DEFAULT = 24;
    localparam int ABORT_CYCLES      = 2;

endpackage

// File: rtl/rc4_prio_pick.sv
// Lowest-index-first one-hot priority picker.
// Combinational; callers register whatever they derive from the grant.
module rc4_prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt,
    output logic         o_valid
);

    // Two's-complement trick isolates the least significant set bit.
    assign o_gnt   = i_req & (~i_req + N'(1));
    assign o_valid = |i_req;

endmodule

// File: rtl/rc4_key_scheduler.sv
// Hands ascending candidate keys to NUM_CORES RC4 cracker cores, gathers
// their verdicts, aborts everything on the first hit, flags exhaustion otherwise.
module rc4_key_scheduler
    import rc4_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [NUM_CORES-1:0]           core_ready,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic                           core_abort,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           result_key,
    output logic [KEY_WIDTH-1:0]           display_key
);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic                   r_start_d;
    logic [KEY_WIDTH:0]     r_next_key;
    logic [NUM_CORES-1:0]   r_in_flight;
    logic [KEY_WIDTH-1:0]   r_key [NUM_CORES];
    logic [NUM_CORES-1:0]   r_core_start;
    logic                   r_abort;
    logic [1:0]             r_abort_cnt;
    logic                   r_busy;
    logic                   r_found;
    logic                   r_exhausted;
    logic [KEY_WIDTH-1:0]   r_result_key;
    logic [KEY_WIDTH-1:0]   r_display_key;

    logic                   w_start_edge;
    logic                   w_clear;
    logic                   w_keys_left;
    logic [NUM_CORES-1:0]   w_done_live;
    logic [NUM_CORES-1:0]   w_inflight_after;
    logic [NUM_CORES-1:0]   w_found_req;
    logic [NUM_CORES-1:0]   w_found_gnt;
    logic                   w_found_any;
    logic [NUM_CORES-1:0]   w_disp_req;
    logic [NUM_CORES-1:0]   w_disp_gnt;
    logic                   w_disp_any;
    logic [KEY_WIDTH-1:0]   w_found_key;

    assign w_start_edge     = start & ~r_start_d;
    // One extra bit on next_key keeps KEY_MAX+1 distinct from key 0.
    assign w_keys_left      = (r_next_key <= {1'b0, KEY_MAX});
    assign w_done_live      = core_done & r_in_flight;
    assign w_inflight_after = r_in_flight & ~w_done_live;
    assign w_found_req      = (r_state == RUN) ? (w_done_live & core_found) : '0;
    assign w_disp_req       = ((r_state == RUN) && w_keys_left && !w_found_any)
                              ? (core_ready & ~r_in_flight) : '0;

    rc4_prio_pick #(.N(NUM_CORES)) u_found_pick (
        .i_req   (w_found_req),
        .o_gnt   (w_found_gnt),
        .o_valid (w_found_any)
    );

    rc4_prio_pick #(.N(NUM_CORES)) u_disp_pick (
        .i_req   (w_disp_req),
        .o_gnt   (w_disp_gnt),
        .o_valid (w_disp_any)
    );

    // Key held by the winning core, selected by the one-hot found grant.
    always_comb begin
        w_found_key = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_found_key = w_found_key | (r_key[i] & {KEY_WIDTH{w_found_gnt[i]}});
        end
    end

    // Next-state logic; found outranks exhaustion in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_edge) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            RUN: begin
                if (w_found_any) begin
                    w_state_nxt = ABORT;
                end else if (!w_keys_left && (w_inflight_after == '0)) begin
                    w_state_nxt = FAIL;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            ABORT: begin
                if (r_abort_cnt == 2'(ABORT_CYCLES - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ABORT;
                end
            end
            FAIL:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control, status and key-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_d     <= 1'b0;
            r_next_key    <= '0;
            r_in_flight   <= '0;
            r_core_start  <= '0;
            r_abort       <= 1'b0;
            r_abort_cnt   <= 2'd0;
            r_busy        <= 1'b0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_result_key  <= '0;
            r_display_key <= '0;
        end else begin
            r_start_d    <= start;
            r_core_start <= w_disp_gnt;
            r_abort      <= (w_state_nxt == ABORT);
            r_abort_cnt  <= (r_state == ABORT) ? (r_abort_cnt + 2'd1) : 2'd0;
            r_busy       <= (w_state_nxt == RUN) || (w_state_nxt == ABORT) ||
                            (w_state_nxt == FAIL);
            r_in_flight  <= (r_state == RUN) ? (w_inflight_after | w_disp_gnt) : '0;

            if (w_clear) begin
                r_next_key <= '0;
            end else if (w_disp_any) begin
                r_next_key <= r_next_key + (KEY_WIDTH + 1)'(1);
            end

            if (w_disp_any) begin
                r_display_key <= r_next_key[KEY_WIDTH-1:0];
            end

            if (w_clear) begin
                r_found      <= 1'b0;
                r_exhausted  <= 1'b0;
                r_result_key <= '0;
            end else begin
                if (w_found_any) begin
                    r_found      <= 1'b1;
                    r_result_key <= w_found_key;
                end
                if ((r_state == RUN) && (w_state_nxt == FAIL)) begin
                    r_exhausted <= 1'b1;
                end
            end
        end
    end

    // Per-core key slices, held from dispatch until the core is reused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_key[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_disp_gnt[i]) begin
                    r_key[i] <= r_next_key[KEY_WIDTH-1:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_key_out
        assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = r_key[g];
    end

    assign core_start  = r_core_start;
    assign core_abort  = r_abort;
    assign busy        = r_busy;
    assign found       = r_found;
    assign exhausted   = r_exhausted;
    assign result_key  = r_result_key;
    assign display_key = r_display_key;

endmodule

// File: tb/tb_rc4_key_scheduler.sv
// Scoreboarded bench: behavioural cracker cores drive the scheduler, a monitor
// checks dispatch order and final outcomes against queued expectations.
module tb_rc4_key_scheduler;

    localparam int NC   = 4;
    localparam int KW   = 24;
    localparam int KMAX = 15;

    typedef struct {
        bit f;
        bit x;
        int key;
    } outcome_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [NC-1:0]   core_ready;
    logic [NC-1:0]   core_done;
    logic [NC-1:0]   core_found;
    logic [NC-1:0]   core_start;
    logic [NC*KW-1:0] core_key;
    logic            core_abort;
    logic            busy;
    logic            found;
    logic            exhausted;
    logic [KW-1:0]   result_key;
    logic [KW-1:0]   display_key;

    int       n_tests = 0;
    int       n_fail = 0;
    int       cyc = 0;
    int       exp_keys[$];
    outcome_t exp_out[$];
    int       lat_tbl[KMAX+1];
    bit       secret_tbl[KMAX+1];
    bit       mon_en = 1'b0;
    bit       found_pushed = 1'b0;
    int       last_fd_cyc = -10;
    int       spur_core = -1;

    rc4_key_scheduler #(
        .NUM_CORES (NC),
        .KEY_WIDTH (KW),
        .KEY_MAX   (24'(KMAX))
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .core_ready  (core_ready),
        .core_done   (core_done),
        .core_found  (core_found),
        .core_start  (core_start),
        .core_key    (core_key),
        .core_abort  (core_abort),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .result_key  (result_key),
        .display_key (display_key)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, longint got, longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(string name, longint got);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d, expected no such event (cycle %0d)", name, got, cyc);
    endtask

    function automatic int lat_of(int k);
        return (k >= 0 && k <= KMAX) ? lat_tbl[k] : 1;
    endfunction

    function automatic bit sec_of(int k);
        return (k >= 0 && k <= KMAX) ? secret_tbl[k] : 1'b0;
    endfunction

    task automatic set_const(int l);
        for (int k = 0; k <= KMAX; k++) begin
            lat_tbl[k]    = l;
            secret_tbl[k] = 1'b0;
        end
    endtask

    // Behavioural cracker cores: fixed per-key latency, verdict from secret table.
    initial begin : core_model
        bit busy_m[NC];
        int cnt[NC];
        int key_m[NC];
        bit any_f;
        int win_key;
        core_ready = '1;
        core_done  = '0;
        core_found = '0;
        for (int i = 0; i < NC; i++) begin
            busy_m[i] = 1'b0;
            cnt[i]    = 0;
            key_m[i]  = 0;
        end
        forever begin
            @(negedge clk);
            core_done  = '0;
            core_found = '0;
            if (!reset_n || core_abort) begin
                for (int i = 0; i < NC; i++) busy_m[i] = 1'b0;
                core_ready = '1;
            end else begin
                any_f   = 1'b0;
                win_key = 0;
                if (spur_core >= 0 && !busy_m[spur_core] && !core_start[spur_core]) begin
                    core_done[spur_core]  = 1'b1;
                    core_found[spur_core] = 1'b1;
                    spur_core = -1;
                end
                for (int i = 0; i < NC; i++) begin
                    if (busy_m[i]) begin
                        check("key_hold", core_key[i*KW +: KW], key_m[i]);
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            busy_m[i]     = 1'b0;
                            core_ready[i] = 1'b1;
                            core_done[i]  = 1'b1;
                            core_found[i] = sec_of(key_m[i]);
                            if (sec_of(key_m[i]) && !any_f) begin
                                any_f   = 1'b1;
                                win_key = key_m[i];
                            end
                        end
                    end
                end
                if (any_f && !found_pushed) begin
                    exp_out.push_back('{1'b1, 1'b0, win_key});
                    found_pushed = 1'b1;
                    last_fd_cyc  = cyc;
                end
                for (int i = 0; i < NC; i++) begin
                    if (core_start[i]) begin
                        busy_m[i]     = 1'b1;
                        core_ready[i] = 1'b0;
                        key_m[i]      = int'(core_key[i*KW +: KW]);
                        cnt[i]        = lat_of(key_m[i]);
                    end
                end
            end
        end
    end

    // Monitor: pops expected keys on each dispatch and expected outcome when busy drops.
    initial begin : monitor
        bit       prev_busy;
        bit       prev_found;
        int       abort_cnt;
        int       k;
        outcome_t o;
        prev_busy  = 1'b0;
        prev_found = 1'b0;
        abort_cnt  = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (core_start != '0) begin
                    check("start_onehot", $countones(core_start), 1);
                    check("start_after_found", found, 0);
                    for (int i = 0; i < NC; i++) begin
                        if (core_start[i]) begin
                            k = int'(core_key[i*KW +: KW]);
                            if (exp_keys.size() == 0) begin
                                fail_now("extra_dispatch", k);
                            end else begin
                                check("dispatch_key", k, exp_keys.pop_front());
                            end
                            check("display_key", display_key, k);
                        end
                    end
                end
                if (core_abort) abort_cnt++;
                if (found && !prev_found) check("found_latency", cyc, last_fd_cyc + 1);
                if (prev_busy && !busy) begin
                    if (exp_out.size() == 0) begin
                        fail_now("outcome_missing", found);
                    end else begin
                        o = exp_out.pop_front();
                        check("outcome_found", found, o.f);
                        check("outcome_exhausted", exhausted, o.x);
                        check("outcome_result_key", result_key, o.key);
                        check("abort_cycles", abort_cnt, o.f ? 2 : 0);
                    end
                    abort_cnt = 0;
                end
                prev_busy  = busy;
                prev_found = found;
            end else begin
                prev_busy  = 1'b0;
                prev_found = 1'b0;
                abort_cnt  = 0;
            end
        end
    end

    task automatic launch();
        bit none;
        none = 1'b1;
        for (int k = 0; k <= KMAX; k++) if (secret_tbl[k]) none = 1'b0;
        exp_keys.delete();
        for (int k = 0; k <= KMAX; k++) exp_keys.push_back(k);
        found_pushed = 1'b0;
        if (none) exp_out.push_back('{1'b0, 1'b1, 0});
        start = 1'b1;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("flags_cleared", {found, exhausted}, 0);
        check("result_cleared", result_key, 0);
        check("no_early_start", core_start, 0);
        start = 1'b0;
        @(negedge clk);
        check("first_start_latency", core_start, 1);
        check("first_key", core_key[KW-1:0], 0);
    endtask

    task automatic wait_done(string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now({tag, "_timeout"}, n);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_key(int k);
        int n;
        n = 0;
        while (display_key != KW'(k) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (display_key != KW'(k)) fail_now("wait_key_timeout", display_key);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset_n = 1'b0;
        start   = 1'b0;
        set_const(3);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_found", found, 0);
        check("rst_exhausted", exhausted, 0);
        check("rst_abort", core_abort, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_key", longint'(|core_key), 0);
        check("rst_result_key", result_key, 0);
        check("rst_display_key", display_key, 0);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Full exhaustion with random latencies, a stray start edge and stray dones.
        for (int k = 0; k <= KMAX; k++) lat_tbl[k] = int'($urandom_range(1, 6));
        launch();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_key(KMAX);
        spur_core = 1;
        wait_done("exhaust");
        check("all_keys_dispatched", exp_keys.size(), 0);
        spur_core = 2;
        repeat (3) @(negedge clk);
        check("spur_injected", spur_core, -1);
        check("done_hold_exhausted", exhausted, 1);
        check("done_hold_found", found, 0);
        check("done_hold_busy", busy, 0);
        spur_core = -1;

        // Single hit on key 3.
        set_const(3);
        secret_tbl[3] = 1'b1;
        launch();
        wait_done("found3");
        check("found3_result", result_key, 3);
        check("found3_flag", found, 1);

        // Keys 4 (core 0) and 6 (core 2) report found in the same cycle.
        set_const(3);
        lat_tbl[4]    = 5;
        secret_tbl[4] = 1'b1;
        secret_tbl[6] = 1'b1;
        launch();
        wait_done("tie");
        check("tie_result", result_key, 4);

        // Last key found in the very cycle the search would otherwise exhaust.
        set_const(3);
        secret_tbl[KMAX] = 1'b1;
        launch();
        wait_done("lastkey");
        check("lastkey_found", found, 1);
        check("lastkey_exhausted", exhausted, 0);
        check("lastkey_result", result_key, KMAX);

        // Reset in the middle of RUN with next_key = 7.
        set_const(3);
        launch();
        wait_key(6);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_start", core_start, 0);
        check("midrst_abort", core_abort, 0);
        check("midrst_key", longint'(|core_key), 0);
        check("midrst_display", display_key, 0);
        check("midrst_flags", {found, exhausted}, 0);
        check("midrst_result", result_key, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_keys.delete();
        exp_out.delete();
        mon_en = 1'b1;

        // Randomised searches after the reset.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k <= KMAX; k++) begin
                lat_tbl[k]    = int'($urandom_range(1, 6));
                secret_tbl[k] = 1'b0;
            end
            if (r != 0) begin
                for (int s = 0; s < r % 3 + 1; s++) secret_tbl[$urandom_range(0, KMAX)] = 1'b1;
            end
            launch();
            wait_done("random");
        end

        check("outcomes_drained", exp_out.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
